// File: rtl/gbf_stream_loader.sv
// gbf_stream_loader: accepts stream words and fills two GBF banks alternately,
// tracking which bank holds a complete, unreleased tile.
module gbf_stream_loader #(
  parameter int GBF_DATA_BITWIDTH = 512,
  parameter int GBF_ADDR_BITWIDTH = 5,
  parameter int GBF_DEPTH         = 32,
  parameter int TILE_CNT_BITWIDTH = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [TILE_CNT_BITWIDTH-1:0]   num_tiles,
  input  logic [GBF_ADDR_BITWIDTH:0]     fill_words,
  input  logic                           in_valid,
  input  logic [GBF_DATA_BITWIDTH-1:0]   in_data,
  output logic                           in_ready,
  input  logic                           gbf1_need_data,
  input  logic                           gbf2_need_data,
  output logic                           en1a,
  output logic                           we1a,
  output logic                           en2a,
  output logic                           we2a,
  output logic [GBF_ADDR_BITWIDTH-1:0]   addr1a,
  output logic [GBF_ADDR_BITWIDTH-1:0]   addr2a,
  output logic [GBF_DATA_BITWIDTH-1:0]   w_data1a,
  output logic [GBF_DATA_BITWIDTH-1:0]   w_data2a,
  output logic                           buf1_ready,
  output logic                           buf2_ready,
  output logic                           data_avail,
  output logic                           load_done
);
  localparam int A = GBF_ADDR_BITWIDTH;
  localparam int D = GBF_DATA_BITWIDTH;
  localparam int T = TILE_CNT_BITWIDTH;
  localparam logic [A:0]   ONE_W  = {{A{1'b0}}, 1'b1};
  localparam logic [A:0]   FW_MAX = (A+1)'(GBF_DEPTH);
  localparam logic [A-1:0] ONE_A  = {{(A-1){1'b0}}, 1'b1};
  localparam logic [T-1:0] ONE_T  = {{(T-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, FILL, WAIT, DONE} state_t;

  state_t       state_q, state_d;
  logic         tgt_q, tgt_d;
  logic [A-1:0] w_q, w_d, lw_q, lw_d;
  logic [T-1:0] tiles_q, tiles_d, num_q, num_d;
  logic         buf1_q, buf1_d, buf2_q, buf2_d, pend1_q, pend1_d, pend2_q, pend2_d;
  logic         rdy_q, rdy_d, done_q, done_d, avail_q, avail_d, en1_q, en1_d, en2_q, en2_d;
  logic [A-1:0] a1_q, a1_d, a2_q, a2_d;
  logic [D-1:0] d1_q, d1_d, d2_q, d2_d;
  logic [A:0]   fw_c;
  logic         beat, last, occ1, occ2, tgt_occ, nxt_occ;

  assign fw_c    = fill_words > FW_MAX ? FW_MAX : fill_words;
  assign beat    = in_valid & rdy_q;
  assign last    = beat && w_q == lw_q;
  // A bank whose last write is still in flight counts as occupied
  assign occ1    = buf1_q | pend1_q;
  assign occ2    = buf2_q | pend2_q;
  assign tgt_occ = tgt_q ? occ2 : occ1;
  assign nxt_occ = tgt_q ? occ1 : occ2;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    w_d     = w_q;
    tiles_d = tiles_q;
    num_d   = num_q;
    lw_d    = lw_q;
    if (start && (state_q == IDLE || state_q == DONE)) begin
      num_d   = num_tiles;
      lw_d    = A'(fw_c - ONE_W);
      tiles_d = '0;
      tgt_d   = 1'b0;
      w_d     = '0;
      state_d = num_tiles == '0 ? DONE : occ1 ? WAIT : FILL;
    end else if (state_q == WAIT) begin
      state_d = tgt_occ ? WAIT : FILL;
    end else if (last) begin
      w_d     = '0;
      tiles_d = tiles_q + ONE_T;
      tgt_d   = tiles_d == num_q ? tgt_q : ~tgt_q;
      state_d = tiles_d == num_q ? DONE : nxt_occ ? WAIT : FILL;
    end else if (beat) begin
      w_d = w_q + ONE_A;
    end
    pend1_d = last & ~tgt_q;
    pend2_d = last & tgt_q;
    buf1_d  = pend1_q | (buf1_q & ~gbf1_need_data);
    buf2_d  = pend2_q | (buf2_q & ~gbf2_need_data);
    avail_d = buf1_d | buf2_d;
    rdy_d   = state_d == FILL && !last;
    done_d  = state_d == DONE;
    en1_d   = beat & ~tgt_q;
    en2_d   = beat & tgt_q;
    a1_d    = en1_d ? w_q : '0;
    a2_d    = en2_d ? w_q : '0;
    d1_d    = en1_d ? in_data : '0;
    d2_d    = en2_d ? in_data : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      w_q     <= '0;
      lw_q    <= '0;
      tiles_q <= '0;
      num_q   <= '0;
      buf1_q  <= 1'b0;
      buf2_q  <= 1'b0;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      avail_q <= 1'b0;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      w_q     <= w_d;
      lw_q    <= lw_d;
      tiles_q <= tiles_d;
      num_q   <= num_d;
      buf1_q  <= buf1_d;
      buf2_q  <= buf2_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      avail_q <= avail_d;
      en1_q   <= en1_d;
      en2_q   <= en2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
    end
  end

  assign in_ready   = rdy_q;
  assign en1a       = en1_q;
  assign we1a       = en1_q;
  assign en2a       = en2_q;
  assign we2a       = en2_q;
  assign addr1a     = a1_q;
  assign addr2a     = a2_q;
  assign w_data1a   = d1_q;
  assign w_data2a   = d2_q;
  assign buf1_ready = buf1_q;
  assign buf2_ready = buf2_q;
  assign data_avail = avail_q;
  assign load_done  = done_q;
endmodule

// File: tb/tb_gbf_stream_loader.sv
// tb_gbf_stream_loader: directed vector table plus hand-timed sequences for
// the double-buffered stream loader.
module tb_gbf_stream_loader;
  localparam int DW = 512, AW = 5, TW = 16;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [TW-1:0] num_tiles = '0;
  logic [AW:0] fill_words = '0;
  logic [DW-1:0] in_data = '0;
  logic need1 = 1'b0, need2 = 1'b0;
  logic in_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, load_done;
  logic [AW-1:0] addr1a, addr2a;
  logic [DW-1:0] w_data1a, w_data2a;
  logic [8:0] st;

  gbf_stream_loader dut (
    .clk(clk), .reset(reset), .start(start), .num_tiles(num_tiles), .fill_words(fill_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .gbf1_need_data(need1), .gbf2_need_data(need2),
    .en1a(en1a), .we1a(we1a), .en2a(en2a), .we2a(we2a),
    .addr1a(addr1a), .addr2a(addr2a), .w_data1a(w_data1a), .w_data2a(w_data2a),
    .buf1_ready(buf1_ready), .buf2_ready(buf2_ready), .data_avail(data_avail), .load_done(load_done)
  );

  always #5 clk = ~clk;

  assign st = {in_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail, load_done};

  int passed = 0, total = 0, cyc = 0, nb = 0;
  logic e1, e2, r, b1, b2;

  typedef struct {
    logic st; logic [TW-1:0] nt; logic [AW:0] fw; logic v; logic [7:0] d; logic n1, n2;
    logic [8:0] e_st; logic [AW-1:0] e_a1, e_a2; logic [7:0] e_d1, e_d2;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string n, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, got, exp);
  endtask

  function automatic logic [DW-1:0] word(input int k);
    return {16{32'hC0DE0000 ^ 32'(k)}};
  endfunction

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; need1 = 1'b0; need2 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1; nb = 0;
  endtask

  task automatic cyc_step(input logic v);
    in_valid = v;
    in_data = word(nb);
    if (v && in_ready) nb++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic chk_ports(input string n, input logic [8:0] es, input int a1, input int a2,
                           input logic [DW-1:0] d1, input logic [DW-1:0] d2);
    chk({n, "_status"}, st, es);
    chk({n, "_addr1"}, addr1a, a1);
    chk({n, "_addr2"}, addr2a, a2);
    chk({n, "_wdata1"}, w_data1a, d1);
    chk({n, "_wdata2"}, w_data2a, d2);
  endtask

  // Two 32-word fills with in_valid held: cycle c counted from the start pulse
  task automatic chk_full(input int c);
    cyc = c;
    e1 = c >= 2 && c <= 33;
    e2 = c >= 35 && c <= 66;
    r  = (c >= 1 && c <= 32) || (c >= 34 && c <= 65);
    chk_ports("full", {r, e1, e1, e2, e2, c >= 34, c >= 67, c >= 34, c >= 66},
              e1 ? c - 2 : 0, e2 ? c - 35 : 0, e1 ? word(c - 2) : '0, e2 ? word(c - 3) : '0);
  endtask

  initial begin
    tbl[0]  = '{1, 3, 2, 1, 8'hA0, 0, 0, 9'b000000000, 0, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 0, 0, 1, 8'hA1, 0, 0, 9'b100000000, 0, 0, 8'h00, 8'h00};
    tbl[2]  = '{0, 0, 0, 1, 8'hA2, 0, 0, 9'b111000000, 0, 0, 8'hA1, 8'h00};
    tbl[3]  = '{0, 0, 0, 1, 8'hA3, 0, 0, 9'b011000000, 1, 0, 8'hA2, 8'h00};
    tbl[4]  = '{0, 0, 0, 0, 8'hA4, 0, 0, 9'b100001010, 0, 0, 8'h00, 8'h00};
    tbl[5]  = '{0, 0, 0, 1, 8'hB0, 0, 0, 9'b100001010, 0, 0, 8'h00, 8'h00};
    tbl[6]  = '{0, 0, 0, 1, 8'hB1, 0, 0, 9'b100111010, 0, 0, 8'h00, 8'hB0};
    tbl[7]  = '{0, 0, 0, 1, 8'hB2, 0, 0, 9'b000111010, 0, 1, 8'h00, 8'hB1};
    tbl[8]  = '{0, 0, 0, 1, 8'hB3, 1, 0, 9'b000001110, 0, 0, 8'h00, 8'h00};
    tbl[9]  = '{0, 0, 0, 1, 8'hB4, 0, 0, 9'b000000110, 0, 0, 8'h00, 8'h00};
    tbl[10] = '{1, 0, 2, 1, 8'hC0, 0, 0, 9'b100000110, 0, 0, 8'h00, 8'h00};
    tbl[11] = '{0, 0, 0, 1, 8'hC1, 0, 0, 9'b111000110, 0, 0, 8'hC0, 8'h00};
    tbl[12] = '{0, 0, 0, 1, 8'hC2, 0, 1, 9'b011000111, 1, 0, 8'hC1, 8'h00};
    tbl[13] = '{0, 0, 0, 1, 8'hC3, 0, 0, 9'b000001011, 0, 0, 8'h00, 8'h00};
    tbl[14] = '{1, 0, 2, 0, 8'h00, 0, 0, 9'b000001011, 0, 0, 8'h00, 8'h00};
    tbl[15] = '{0, 0, 0, 0, 8'h00, 1, 0, 9'b000001011, 0, 0, 8'h00, 8'h00};
    tbl[16] = '{0, 0, 0, 0, 8'h00, 0, 0, 9'b000000001, 0, 0, 8'h00, 8'h00};

    // Vector table: 3 tiles of 2 words, WAIT, release, ignored mid-fill start, DONE
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cyc = i;
      chk_ports("tbl", tbl[i].e_st, tbl[i].e_a1, tbl[i].e_a2, {64{tbl[i].e_d1}}, {64{tbl[i].e_d2}});
      start = tbl[i].st; num_tiles = tbl[i].nt; fill_words = tbl[i].fw;
      in_valid = tbl[i].v; in_data = {64{tbl[i].d}}; need1 = tbl[i].n1; need2 = tbl[i].n2;
      @(negedge clk);
    end

    // Two full 32-word fills
    do_reset();
    num_tiles = 2; fill_words = 32; start = 1'b1;
    for (int c = 0; c <= 70; c++) begin
      chk_full(c);
      cyc_step(1'b1);
    end

    // 4 tiles of 4 words, no release until bank 1 is freed at cycle 15
    do_reset();
    num_tiles = 4; fill_words = 4; start = 1'b1;
    for (int c = 0; c <= 24; c++) begin
      cyc = c;
      e1 = (c >= 2 && c <= 5) || (c >= 18 && c <= 21);
      e2 = c >= 7 && c <= 10;
      r  = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 17 && c <= 20);
      b1 = (c >= 6 && c <= 15) || c >= 22;
      b2 = c >= 11;
      chk_ports("wait", {r, e1, e1, e2, e2, b1, b2, b1 | b2, 1'b0},
                e1 ? (c >= 18 ? c - 18 : c - 2) : 0, e2 ? c - 7 : 0,
                e1 ? word(c >= 18 ? c - 10 : c - 2) : '0, e2 ? word(c - 3) : '0);
      need1 = c == 15;
      cyc_step(1'b1);
    end
    need1 = 1'b0;

    // in_valid toggling 1,0,1,0 during a single 4-word fill
    do_reset();
    num_tiles = 1; fill_words = 4; start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      cyc = c;
      e1 = c >= 2 && c <= 8 && c % 2 == 0;
      chk_ports("toggle", {c >= 1 && c <= 7, e1, e1, 1'b0, 1'b0, c >= 9, 1'b0, c >= 9, c >= 8},
                e1 ? (c - 2) / 2 : 0, 0, e1 ? word((c - 2) / 2) : '0, '0);
      cyc_step(c % 2 == 1);
    end

    // need2 during bank 2 fill is ignored; simultaneous release of both banks
    do_reset();
    num_tiles = 3; fill_words = 4; start = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      cyc = c;
      e1 = (c >= 2 && c <= 5) || (c >= 15 && c <= 18);
      e2 = c >= 7 && c <= 10;
      r  = (c >= 1 && c <= 4) || (c >= 6 && c <= 9) || (c >= 14 && c <= 17);
      b1 = (c >= 6 && c <= 12) || c >= 19;
      b2 = c >= 11 && c <= 12;
      chk_ports("release", {r, e1, e1, e2, e2, b1, b2, b1 | b2, c >= 18},
                e1 ? (c >= 15 ? c - 15 : c - 2) : 0, e2 ? c - 7 : 0,
                e1 ? word(c >= 15 ? c - 7 : c - 2) : '0, e2 ? word(c - 3) : '0);
      need1 = c == 12;
      need2 = c == 7 || c == 12;
      cyc_step(1'b1);
    end
    need1 = 1'b0; need2 = 1'b0;

    // Asynchronous reset at beat 10, then a clean restart
    do_reset();
    num_tiles = 2; fill_words = 32; start = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      chk_full(c);
      cyc_step(1'b1);
    end
    chk_full(11);
    #2 reset = 1'b0;
    #1 chk_ports("async_rst", 9'b0, 0, 0, '0, '0);
    @(negedge clk);
    reset = 1'b1; nb = 0;
    num_tiles = 2; fill_words = 32; start = 1'b1;
    for (int c = 0; c <= 36; c++) begin
      chk_full(c);
      cyc_step(1'b1);
    end

    // num_tiles == 0 goes straight to DONE with no writes
    do_reset();
    num_tiles = 0; fill_words = 4; start = 1'b1;
    for (int c = 0; c <= 3; c++) begin
      cyc = c;
      chk_ports("zero", c >= 1 ? 9'b000000001 : 9'b0, 0, 0, '0, '0);
      cyc_step(1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gbf_stream_loader.md
# gbf_stream_loader

Upstream fill stage for one double-buffered global buffer (GBF) pair in front of gbf_pe_array; one instance drives activation, another drives weights. It accepts 512-bit words from the off-chip stream with a valid/ready handshake and writes them through port A of GBF bank 1 or bank 2, alternating between the banks. It reports bank occupancy to gbf_controller_new through buf1_ready, buf2_ready and data_avail. It refills a bank when that bank's need_data is raised.

## Interface
- GBF_DATA_BITWIDTH, 512, stream word and GBF port-A data width
- GBF_ADDR_BITWIDTH, 5, GBF port-A address width
- GBF_DEPTH, 32, words per GBF bank
- TILE_CNT_BITWIDTH, 16, width of num_tiles and the tile counter

- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches num_tiles and fill_words, begins loading
- num_tiles  in  TILE_CNT_BITWIDTH  total bank fills for the layer
- fill_words  in  GBF_ADDR_BITWIDTH+1  words per fill, 1..GBF_DEPTH
- in_valid  in  1  stream word valid
- in_data  in  GBF_DATA_BITWIDTH  stream word
- in_ready  out  1  loader accepts a word this cycle
- gbf1_need_data, gbf2_need_data  in  1  from gbf_controller_new; bank consumed, release it
- en1a, we1a, en2a, we2a  out  1  GBF port-A enable/write for bank 1 and bank 2
- addr1a, addr2a  out  GBF_ADDR_BITWIDTH  port-A address
- w_data1a, w_data2a  out  GBF_DATA_BITWIDTH  port-A write data
- buf1_ready, buf2_ready  out  1  bank holds a complete, unreleased tile
- data_avail  out  1  buf1_ready | buf2_ready
- load_done  out  1  all num_tiles fills written; held until next start

## Operation
- States:
  - IDLE: wait for start.
  - FILL: write the target bank.
  - WAIT: target bank still occupied.
  - DONE: all fills written.
- Target bank toggle: resets to bank 1 and toggles after every completed fill, giving the order 1,2,1,2,…
- start in IDLE or DONE:
  - latches num_tiles and fill_words; clears the tile counter, load_done and the target toggle.
  - next state is DONE if num_tiles==0; otherwise FILL if the target bank is empty, else WAIT.
- start in FILL or WAIT is ignored.
- FILL:
  - in_ready=1.
  - Each beat (in_valid & in_ready) writes in_data to the target bank at word counter w, then increments w.
  - w runs 0..fill_words-1; there is no wrap inside a fill.
  - On the last beat, w is cleared and the tile counter increments.
  - If tile count == num_tiles, the next state is DONE. Otherwise the toggle flips, and the next state is FILL if the new target is empty, else WAIT.
- WAIT: in_ready=0; move to FILL when the target bank's bufX_ready is 0.
- DONE: in_ready=0; load_done=1.
- Release: gbfX_need_data=1 while bufX_ready=1 clears bufX_ready on the next edge.
  - need_data for a bank that is not ready (empty or still filling) is ignored; it does not abort the fill.
  - Release is accepted in every state, including DONE.
- Both need_data inputs high together: both banks release in the same cycle.
- Release of the target bank in the WAIT cycle: the transition to FILL occurs one cycle after bufX_ready falls.
- The non-target bank's port-A outputs stay 0 at all times.
- Reset is asynchronous and may arrive mid-fill. It forces IDLE and clears all outputs. Partial bank contents are not marked ready.

## Timing
- Reset values: in_ready, en1a, we1a, en2a, we2a, buf1_ready, buf2_ready, data_avail and load_done are 0; addr1a, addr2a, w_data1a and w_data2a are 0.
- Port-A outputs are registered. A beat accepted in cycle t gives enXa=weXa=1 with the addr/data of that beat during cycle t+1. At all other times enXa=weXa=0.
- Last beat in cycle t:
  - its write is presented in cycle t+1.
  - bufX_ready=1 from cycle t+2.
  - data_avail follows in the same cycle as bufX_ready.
- in_ready:
  - is registered from the state and is 1 in the first FILL cycle.
  - drops in the cycle after the last beat of a fill.
  - rises again next cycle if the other bank is empty, so back-to-back fills lose one cycle.
- Throughput in FILL: one word per cycle while in_valid is held high.
- load_done rises in the cycle after the last beat, i.e. the same cycle as that fill's final write.

## Test plan
- Reset, then start with num_tiles=2 and fill_words=32, with in_valid held 1:
  - 32 writes to bank 1 at addresses 0..31, then 32 writes to bank 2.
  - buf1_ready rises 2 cycles after beat 31.
  - load_done=1; in_ready=0 thereafter.
- num_tiles=4, fill_words=4, with need_data never asserted:
  - banks 1 and 2 fill, then the loader holds WAIT with in_ready=0.
  - Pulse gbf1_need_data: buf1_ready falls, bank 1 refills (tile 3), and buf1_ready rises.
- in_valid toggling 1,0,1,0 during a fill: writes appear only in the cycles after accepted beats, with addresses contiguous 0,1,2,3.
- gbf2_need_data pulsed while bank 2 is mid-fill, then both need_data inputs pulsed together while both banks are ready:
  - the first pulse is ignored and the fill completes.
  - the simultaneous pulse clears both ready flags in one cycle, and refill order is target-first.
- reset asserted at beat 10 of a fill, then start again:
  - all outputs are 0 immediately; the new fill begins at bank 1, address 0.
  - buf1_ready stays 0 until the new fill completes.
- start with num_tiles=0 → DONE and load_done=1 in the next cycle, with no writes. A start pulse in mid-FILL is ignored, and the counters are unchanged.
